bash_echo_exec: RTL

BASH_ECHO_EXEC -- requirements
Module: bash_echo_exec

---
 rtl/bash_echo_exec.sv | 111 +++++++++++
 1 files changed

// File: rtl/bash_echo_exec.sv
// bash_echo_exec: executes the bash "echo" of an input line. The line is
// pulled from the terminal one character at a time into a local buffer.
// It is then played back as a response line terminated by 8'h00. A solved
// pulse tells the terminal that the command is finished and it may restore
// the prompt.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   line_ready/line_len      terminal offers a line of line_len characters
//   line_char/line_next      current character / one-cycle "consumed" pulse
//   resp_ready/resp_char     response character valid / value (00 = end)
//   resp_next                terminal took resp_char (one-cycle pulse)
//   solved/solved_ack        command done pulse / terminal acknowledge
//   busy                     high whenever the FSM is not IDLE
//
// Optional build macro: EXEC_UPPERCASE_EN -- emit lowercase ASCII letters as
// uppercase on resp_char (the buffer itself keeps the original characters).
module bash_echo_exec #(
    parameter int BUF_LEN = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_ready,
    input  logic [12:0] line_len,
    input  logic [7:0]  line_char,
    output logic        line_next,
    output logic        resp_ready,
    output logic [7:0]  resp_char,
    input  logic        resp_next,
    output logic        solved,
    input  logic        solved_ack,
    output logic        busy
);

    localparam int          AW        = (BUF_LEN > 1) ? $clog2(BUF_LEN) : 1;
    localparam logic [12:0] BUF_LEN13 = 13'(BUF_LEN);

    typedef enum logic [2:0] {IDLE, RECV, DRAIN, SEND, SOLVE, ACK} state_t;

    state_t      state_q, state_d;
    logic [12:0] len_q, rx_idx, tx_idx;
    logic [7:0]  line_buf [BUF_LEN];
    logic [7:0]  raw_char;
    logic        sample;

    // A sample is skipped in the cycle where line_next is high, which gives
    // the terminal one cycle to advance its index before the next read.
    assign sample = (state_q == RECV) && (rx_idx < len_q) && !line_next;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (line_ready) state_d = (line_len == 13'd0) ? DRAIN : RECV;
            RECV:  if (rx_idx == len_q) state_d = DRAIN;
            DRAIN: if (!line_ready) state_d = (len_q != 13'd0) ? SEND : SOLVE;
            SEND:  if (resp_next && tx_idx == len_q) state_d = SOLVE;
            SOLVE: state_d = ACK;
            ACK:   if (solved_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            rx_idx    <= '0;
            tx_idx    <= '0;
            line_next <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_next <= sample;
            if (state_q == IDLE && line_ready) begin
                len_q  <= (line_len > BUF_LEN13) ? BUF_LEN13 : line_len;
                rx_idx <= '0;
            end
            if (sample)
                rx_idx <= rx_idx + 13'd1;
            if (state_q == DRAIN)
                tx_idx <= '0;
            // tx_idx parks on len_q while the terminator is presented.
            if (state_q == SEND && resp_next && tx_idx != len_q)
                tx_idx <= tx_idx + 13'd1;
        end
    end

    // Buffer contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        if (sample)
            line_buf[rx_idx[AW-1:0]] <= line_char;
    end

    assign raw_char = (tx_idx == len_q) ? 8'h00 : line_buf[tx_idx[AW-1:0]];

    always_comb begin
        resp_char = 8'h00;
        if (state_q == SEND) begin
            resp_char = raw_char;
`ifdef EXEC_UPPERCASE_EN
            if (raw_char >= 8'h61 && raw_char <= 8'h7A)
                resp_char = raw_char - 8'h20;
`else
`endif
        end
    end

    assign resp_ready = (state_q == SEND);
    assign solved     = (state_q == SOLVE);
    assign busy       = (state_q != IDLE);

endmodule
